// File: rtl/imem_loader.sv
// imem_loader: receives a program as a little-endian byte stream, assembles
// IW-bit instruction words, writes them into instruction memory one word at a
// time and then raises start to let the core run the freshly loaded program.
module imem_loader #(
   parameter int IMW = 4,
   parameter int IW  = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load_req,
   input  logic [IMW:0]   load_len,
   input  logic           byte_valid,
   input  logic [7:0]     byte_data,
   output logic           byte_ready,
   output logic           im_we,
   output logic [IMW-1:0] im_addr,
   output logic [IW-1:0]  im_wdata,
   output logic           start,
   output logic           busy,
   output logic           err
);

   localparam int BPW = IW / 8;
   localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

   // Largest legal program length is the full memory depth, 2^IMW words.
   localparam logic [IMW:0] MAX_LEN = {1'b1, {IMW{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_RUN
   } state_t;

   state_t         state_q, state_d;
   logic [IMW:0]   len_q, len_d;
   logic [IMW-1:0] wcnt_q, wcnt_d;
   logic [BIW-1:0] bidx_q, bidx_d;
   logic [IW-1:0]  word_q, word_d;
   logic           ready_q, ready_d;
   logic           we_q, we_d;
   logic [IMW-1:0] addr_q, addr_d;
   logic [IW-1:0]  wdata_q, wdata_d;
   logic           start_q, start_d;
   logic           busy_q, busy_d;
   logic           err_q, err_d;

   logic           xfer;
   logic           len_ok;
   logic           last_byte;
   logic           last_word;

   assign xfer      = byte_valid & ready_q;
   assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
   assign last_byte = (bidx_q == BIW'(BPW - 1));
   assign last_word = ({1'b0, wcnt_q} == (len_q - (IMW + 1)'(1)));

   // Next-state and next-output computation; every output is registered from
   // the upcoming state so it lines up with the cycle that state is active.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      bidx_d  = bidx_q;
      word_d  = word_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE, S_RUN: begin
            if (load_req) begin
               if (len_ok) begin
                  len_d   = load_len;
                  wcnt_d  = '0;
                  bidx_d  = '0;
                  state_d = S_RECV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_RECV: begin
            if (xfer) begin
               for (int unsigned k = 0; k < BPW; k++) begin
                  if (bidx_q == BIW'(k)) begin
                     word_d[8*k +: 8] = byte_data;
                  end
               end
               if (last_byte) begin
                  // The write port is loaded from the word including the byte
                  // accepted this edge, so WRITE needs no extra cycle.
                  bidx_d  = '0;
                  addr_d  = wcnt_q;
                  wdata_d = word_d;
                  state_d = S_WRITE;
               end else begin
                  bidx_d = bidx_q + BIW'(1);
               end
            end
         end

         S_WRITE: begin
            if (last_word) begin
               state_d = S_RUN;
            end else begin
               wcnt_d  = wcnt_q + IMW'(1);
               state_d = S_RECV;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_RECV);
      we_d    = (state_d == S_WRITE);
      busy_d  = (state_d == S_RECV) || (state_d == S_WRITE);
      start_d = (state_d == S_RUN);
   end

   // State and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         wcnt_q  <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign byte_ready = ready_q;
   assign im_we      = we_q;
   assign im_addr    = addr_q;
   assign im_wdata   = wdata_q;
   assign start      = start_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized program loads checked against a word-level
// reference (expected address/data queue built from the byte list).
module tb_imem_loader;

   localparam int IMW   = 4;
   localparam int IW    = 32;
   localparam int DEPTH = 1 << IMW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           load_req = 1'b0;
   logic [IMW:0]   load_len = '0;
   logic           byte_valid = 1'b0;
   logic [7:0]     byte_data = '0;
   logic           byte_ready;
   logic           im_we;
   logic [IMW-1:0] im_addr;
   logic [IW-1:0]  im_wdata;
   logic           start;
   logic           busy;
   logic           err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [IMW-1:0] exp_addr_q[$];
   logic [IW-1:0]  exp_data_q[$];
   logic           exp_start = 1'b0;

   imem_loader #(.IMW(IMW), .IW(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_req   (load_req),
      .load_len   (load_len),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_wdata   (im_wdata),
      .start      (start),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every memory write must be the next one the reference expects.
   always @(negedge clk) begin
      if (im_we) begin
         if (exp_addr_q.size() == 0) begin
            chk("unexpected_we", im_we, 0);
         end else begin
            chk("we_addr", im_addr, exp_addr_q.pop_front());
            chk("we_data", im_wdata, exp_data_q.pop_front());
            chk("we_no_ready", byte_ready, 0);
            chk("we_busy", busy, 1);
         end
      end
   end

   function automatic void rand_prog(input int len, output logic [7:0] q[$]);
      q = {};
      for (int i = 0; i < len * 4; i++) q.push_back(8'($urandom));
   endfunction

   function automatic void plan(input logic [7:0] bytes[$]);
      int len;
      len = bytes.size() / 4;
      for (int w = 0; w < len; w++) begin
         logic [31:0] d;
         d = '0;
         for (int j = 0; j < 4; j++) d = d + (32'(bytes[4*w+j]) << (8*j));
         exp_addr_q.push_back(IMW'(w));
         exp_data_q.push_back(d);
      end
   endfunction

   // Issue one load_req and check the immediate response.
   task automatic req(input int len, output bit ok);
      ok = (len >= 1) && (len <= DEPTH);
      load_req = 1'b1;
      load_len = (IMW + 1)'(len);
      tick();
      load_req = 1'b0;
      @(negedge clk);
      if (ok) begin
         exp_start = 1'b0;
         chk("req_busy", busy, 1);
         chk("req_ready", byte_ready, 1);
         chk("req_start", start, 0);
         chk("req_noerr", err, 0);
         tick();
      end else begin
         chk("bad_err", err, 1);
         chk("bad_start", start, exp_start);
         chk("bad_busy", busy, 0);
         tick();
         @(negedge clk);
         chk("bad_err_pulse", err, 0);
         tick();
      end
   endtask

   // Offer bytes until all are consumed; pct<0 toggles valid every cycle.
   task automatic feed(input logic [7:0] bytes[$], input int pct, input bit poke, output bit done);
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      while (idx < bytes.size() && cyc < 4000) begin
         if (pct < 0) byte_valid = cyc[0];
         else byte_valid = ($urandom_range(99) < pct);
         byte_data = byte_valid ? bytes[idx] : 8'($urandom);
         if (poke && cyc == 3) begin
            load_req = 1'b1;
            load_len = (IMW + 1)'($urandom);
         end
         @(negedge clk);
         chk("load_busy", busy, 1);
         chk("load_start", start, 0);
         if (poke && cyc == 4) chk("ignored_req", err, 0);
         if (byte_valid && byte_ready) idx++;
         tick();
         load_req = 1'b0;
         cyc++;
      end
      byte_valid = 1'b0;
      done = (idx == bytes.size());
      chk("feed_done", idx, bytes.size());
   endtask

   task automatic do_load(input logic [7:0] bytes[$], input int pct, input bit poke);
      bit ok;
      bit done;
      plan(bytes);
      req(bytes.size() / 4, ok);
      feed(bytes, pct, poke, done);
      if (done) begin
         @(negedge clk);
         chk("lat_we", im_we, 1);
         chk("lat_addr", im_addr, (bytes.size() / 4) - 1);
         chk("lat_start_low", start, 0);
         tick();
         @(negedge clk);
         chk("lat_start", start, 1);
         chk("run_busy", busy, 0);
         chk("run_ready", byte_ready, 0);
         exp_start = 1'b1;
         tick();
      end
      chk("queue_drained", exp_addr_q.size(), 0);
      exp_addr_q = {};
      exp_data_q = {};
   endtask

   initial begin
      logic [7:0] prog[$];
      logic [7:0] part[$];
      bit ok;
      bit done;

      // Power-on reset.
      #2 rst_n = 1'b0;
      #2;
      chk("rst_outs", {byte_ready, im_we, im_addr, im_wdata, start, busy, err}, '0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("idle_after_rst", {busy, byte_ready, start}, 0);
      tick();

      // Rejected lengths from IDLE.
      req(0, ok);
      req(17, ok);

      // Reference two-word program, then the same with toggled valid.
      prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      do_load(prog, 100, 1'b0);
      do_load(prog, -1, 1'b0);

      // Reload from RUN with a single word; rejected length from RUN keeps start.
      req(0, ok);
      prog = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      do_load(prog, 100, 1'b0);
      req(int'($urandom_range(31, 17)), ok);

      // Reset in the middle of word 0: nothing written, outputs cleared at once.
      rand_prog(3, prog);
      plan(prog);
      req(3, ok);
      part = '{prog[0], prog[1]};
      feed(part, 100, 1'b0, done);
      rst_n = 1'b0;
      exp_addr_q = {};
      exp_data_q = {};
      exp_start = 1'b0;
      #1;
      chk("abort_outs", {byte_ready, im_we, im_addr, im_wdata, start, busy, err}, '0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("abort_idle", {busy, byte_ready, start}, 0);
      tick();
      rand_prog(2, prog);
      do_load(prog, 100, 1'b0);

      // Full-depth load with an ignored request while receiving.
      rand_prog(DEPTH, prog);
      do_load(prog, 70, 1'b1);

      // Random loads interleaved with random rejected requests.
      for (int t = 0; t < 6; t++) begin
         if ($urandom_range(1) == 1) req(int'($urandom_range(31, 17)), ok);
         rand_prog(int'($urandom_range(DEPTH, 1)), prog);
         do_load(prog, int'($urandom_range(100, 30)), t[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMW, default 4, instruction-memory address width (2^IMW words).
REQ-002 Parameter IW, default 32, instruction word width; multiple of 8; BPW = IW/8 bytes per word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_req  input  1  single-cycle request to begin a program load.
REQ-006 load_len  input  IMW+1  number of words to load; sampled with load_req.
REQ-007 byte_valid  input  1  source presents a byte on byte_data.
REQ-008 byte_data  input  8  program byte; little-endian within a word.
REQ-009 byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready.
REQ-010 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 im_addr  output  IMW  write address.
REQ-012 im_wdata  output  IW  assembled instruction word.
REQ-013 start  output  1  run enable to core; level, high while program valid.
REQ-014 busy  output  1  high in RECV or WRITE.
REQ-015 err  output  1  one-cycle pulse on rejected load_req.

Function
REQ-016 FSM states SHALL be IDLE, RECV, WRITE, RUN.
REQ-017 IDLE/RUN: byte_ready=0, im_we=0; start=0 in IDLE, start=1 in RUN.
REQ-018 load_req in IDLE or RUN with 1 <= load_len <= 2^IMW: latch load_len, clear word counter and byte index, start<=0, go RECV next cycle.
REQ-019 load_req with load_len=0 or load_len>2^IMW: state and start unchanged, err=1 next cycle.
REQ-020 load_req while in RECV or WRITE: ignored, no err.
REQ-021 RECV: byte_ready=1; each transfer writes byte_data to bits [8k+7:8k] of word register, k = byte index 0..BPW-1, then byte index increments.
REQ-022 byte_valid with byte_ready=0: no transfer, byte_data ignored.
REQ-023 Transfer of byte BPW-1: byte index wraps to 0, go WRITE next cycle.
REQ-024 WRITE (exactly one cycle): im_we=1, im_addr=word counter, im_wdata=assembled word, byte_ready=0.
REQ-025 From WRITE: if word counter = load_len-1 go RUN, else increment word counter and return to RECV.
REQ-026 Latency: last byte accepted at edge N -> im_we high in cycle N+1 -> start high from cycle N+2.
REQ-027 im_addr and im_wdata hold last value outside WRITE; im_we only ever high in WRITE.
REQ-028 Load of 2^IMW words: word counter reaches 2^IMW-1 without overflow; no address wrap.
REQ-029 Reload from RUN: start falls cycle after load_req, stays 0 until new load completes.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, start=0, busy=0, err=0, byte_ready=0, im_we=0, im_addr=0, im_wdata=0, counters 0.
REQ-031 Reset mid-load SHALL abort with no further im_we; partial word discarded.
REQ-032 After rst_n rises, loader stays IDLE until next valid load_req.

Verification
REQ-033 Reset, load_req with load_len=2, bytes 13,00,00,00,93,00,10,00 -> im_we @addr0 data 0x00000013, @addr1 data 0x00100093, start=1 two cycles after last byte.
REQ-034 Same load with byte_valid toggled 0/1 each cycle -> identical writes, only valid&ready bytes consumed.
REQ-035 load_req with load_len=0, then load_len=17 (IMW=4) -> err pulses each, state IDLE, start stays 0.
REQ-036 In RUN, load_req load_len=1, bytes EF,BE,AD,DE -> start falls next cycle, write @addr0 0xDEADBEEF, start rises again.
REQ-037 rst_n low after 2 bytes of word 0 -> all outputs 0 asynchronously, no im_we; fresh load after release writes correctly.
REQ-038 load_len=16 full load -> 16 writes, addresses 0..15 in order, start=1 after addr 15.
